// File: rtl/fp_norm_lz_sequencer.sv
// Sequential mantissa normaliser: scans 6-bit segments MSB-first to find the
// leading-zero count, then shifts and adjusts the exponent in one more cycle.
module fp_norm_lz_sequencer #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int LZ_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic [LZ_W-1:0]   out_lz,
  output logic              out_zero,
  output logic              out_uflow
);
  localparam int NSEG = MANT_W / 6;
  localparam int SW   = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int CW   = ((LZ_W > EXP_W) ? LZ_W : EXP_W) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state;
  logic              armed;
  logic [MANT_W-1:0] mantR;
  logic [EXP_W-1:0]  expR;
  logic [LZ_W-1:0]   lzAcc;
  logic [SW-1:0]     segIdx;
  logic              zeroR;

  logic [5:0]        seg;
  logic [2:0]        segLz;
  logic              segZero;
  logic [CW-1:0]     lzW, expW, shAmt;
  logic              clamp;
  logic [MANT_W-1:0] shifted;

  // armed holds in_ready low until the first edge after reset release
  assign in_ready  = (state == IDLE) && armed;
  assign out_valid = (state == DONE);

  always_comb begin
    seg = '0;
    for (int s = 0; s < NSEG; s++)
      if (segIdx == SW'(s)) seg = mantR[MANT_W-1-6*s -: 6];
  end

  always_comb begin
    segLz = '0;
    for (int b = 0; b < 6; b++)
      if (seg[b]) segLz = 3'(5 - b);
  end

  assign segZero = (seg == 6'd0);

  // Shift is clamped so the exponent never goes below zero
  assign lzW     = CW'(lzAcc);
  assign expW    = CW'(expR);
  assign clamp   = (lzW >= expW);
  assign shAmt   = clamp ? expW : lzW;
  assign shifted = mantR << shAmt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      mantR     <= '0;
      expR      <= '0;
      lzAcc     <= '0;
      segIdx    <= '0;
      zeroR     <= 1'b0;
      out_mant  <= '0;
      out_exp   <= '0;
      out_lz    <= '0;
      out_zero  <= 1'b0;
      out_uflow <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: if (in_valid && in_ready) begin
          mantR  <= in_mant;
          expR   <= in_exp;
          lzAcc  <= '0;
          segIdx <= '0;
          zeroR  <= 1'b0;
          state  <= SCAN;
        end
        SCAN: if (segZero) begin
          lzAcc <= lzAcc + LZ_W'(6);
          if (segIdx == SW'(NSEG - 1)) begin
            zeroR <= 1'b1;
            state <= SHIFT;
          end else begin
            segIdx <= segIdx + SW'(1);
          end
        end else begin
          lzAcc <= lzAcc + LZ_W'(segLz);
          state <= SHIFT;
        end
        SHIFT: begin
          out_lz   <= lzAcc;
          out_zero <= zeroR;
          if (zeroR) begin
            out_mant  <= '0;
            out_exp   <= '0;
            out_uflow <= 1'b0;
          end else begin
            out_mant  <= shifted;
            out_exp   <= clamp ? '0 : EXP_W'(expW - lzW);
            out_uflow <= clamp;
          end
          state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_norm_lz_sequencer.sv
// Randomised bench for fp_norm_lz_sequencer against a plain-arithmetic model
// of normalisation, plus the directed vectors and reset-abort scenario.
module tb_fp_norm_lz_sequencer;
  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [23:0] in_mant = 0;
  logic [7:0]  in_exp = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [23:0] out_mant;
  logic [7:0]  out_exp;
  logic [4:0]  out_lz;
  logic        out_zero;
  logic        out_uflow;

  int errs = 0;
  int checks = 0;

  logic [23:0] eMant;
  logic [7:0]  eExp;
  logic [4:0]  eLz;
  logic        eZero, eUflow;
  int          eK;
  logic        chkEn = 0;

  fp_norm_lz_sequencer #(.MANT_W(24), .EXP_W(8), .LZ_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp), .out_valid(out_valid),
    .out_ready(out_ready), .out_mant(out_mant), .out_exp(out_exp),
    .out_lz(out_lz), .out_zero(out_zero), .out_uflow(out_uflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Normalisation from first principles: find the first set bit, clamp by exp.
  task automatic model(input logic [23:0] m, input logic [7:0] e,
                       output logic [23:0] om, output logic [7:0] oe,
                       output logic [4:0] olz, output logic oz, output logic ou,
                       output int k);
    int lz;
    lz = 24;
    for (int i = 23; i >= 0; i--)
      if (m[i] && lz == 24) lz = 23 - i;
    olz = 5'(lz);
    if (m == 0) begin
      om = 0; oe = 0; oz = 1; ou = 0; k = 4;
    end else begin
      oz = 0;
      k = lz / 6 + 1;
      if (lz < int'(e)) begin
        om = m << lz; oe = 8'(int'(e) - lz); ou = 0;
      end else begin
        om = m << e; oe = 0; ou = 1;
      end
    end
  endtask

  // Single compare process: every cycle a result is presented it must match the model
  always @(negedge clk) begin
    if (!rst && chkEn && out_valid) begin
      chk("out_mant", out_mant, eMant);
      chk("out_exp", out_exp, eExp);
      chk("out_lz", out_lz, eLz);
      chk("out_zero", out_zero, eZero);
      chk("out_uflow", out_uflow, eUflow);
      chk("in_ready_busy", in_ready, 0);
    end
  end

  task automatic doOp(input logic [23:0] m, input logic [7:0] e, input int hold);
    int t, lat;
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    chk("in_ready_wait", in_ready, 1);
    model(m, e, eMant, eExp, eLz, eZero, eUflow, eK);
    in_valid = 1; in_mant = m; in_exp = e; out_ready = 0;
    @(posedge clk);
    #1;
    in_valid = $urandom_range(0, 1); in_mant = $urandom; in_exp = $urandom;
    lat = 0;
    do begin
      @(posedge clk); lat++; #1;
    end while (!out_valid && lat < 20);
    chk("latency", lat, eK + 1);
    chkEn = 1;
    for (int i = 0; i < hold; i++) @(negedge clk);
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1;
    chkEn = 0;
    out_ready = 0;
    in_valid = 0;
    chk("valid_drop", out_valid, 0);
    chk("ready_back", in_ready, 1);
  endtask

  initial begin
    logic [23:0] pm; logic [7:0] pe; logic [4:0] pl; logic pz, pu; int pk;

    // Pin the model to hand-computed vectors
    model(24'h040000, 8'd3, pm, pe, pl, pz, pu, pk);
    chk("pin_mant", pm, 24'h200000); chk("pin_lz", pl, 5); chk("pin_uflow", pu, 1);
    model(24'h000001, 8'd100, pm, pe, pl, pz, pu, pk);
    chk("pin_exp", pe, 77); chk("pin_k", pk, 4);

    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_mant", out_mant, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);

    doOp(24'h800000, 8'd100, 0);
    chk("d1_lz", out_lz, 0);
    doOp(24'h000001, 8'd100, 0);
    chk("d2_exp", out_exp, 77);
    doOp(24'h040000, 8'd3, 0);
    chk("d3_mant", out_mant, 24'h200000);
    doOp(24'h000000, 8'd50, 0);
    chk("d4_zero", out_zero, 1);
    chk("d4_lz", out_lz, 24);
    doOp(24'h123456, 8'd0, 3);   // held 3 cycles, exp=0 clamp

    // Reset during the second SCAN cycle
    @(negedge clk);
    in_valid = 1; in_mant = 24'h000100; in_exp = 8'd40;
    @(posedge clk); #1; in_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("abort_ready", in_ready, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_mant", out_mant, 0);
    chk("abort_lz", out_lz, 0);
    chk("abort_exp", out_exp, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    chk("abort_ready_after", in_ready, 1);
    doOp(24'h400000, 8'd10, 1);
    chk("after_abort_lz", out_lz, 1);
    chk("after_abort_exp", out_exp, 9);

    for (int n = 0; n < 200; n++) begin
      logic [23:0] m;
      logic [7:0] e;
      m = 24'($urandom) & (24'hFFFFFF >> $urandom_range(0, 24));
      e = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 30)) : 8'($urandom);
      doOp(m, e, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
